// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_pattern_gen
// Purpose  : Two-stage VGA test-pattern generator with frame-synchronous
//            pattern select and sync outputs aligned to the colour outputs.
// Revision : 1.0
// ============================================================================
module vga_pattern_gen #(
  parameter int COLOR_BITS  = 3,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int CHECK_LOG2  = 5,
  parameter int COL_W       = 10,
  parameter int ROW_W       = 10
) (
  input  logic                  CLK,
  input  logic                  i_Rst_n,
  input  logic                  i_HSync,
  input  logic                  i_VSync,
  input  logic [2:0]            i_Pattern,
  output logic                  o_HSync,
  output logic                  o_VSync,
  output logic [COLOR_BITS-1:0] o_Red,
  output logic [COLOR_BITS-1:0] o_Green,
  output logic [COLOR_BITS-1:0] o_Blue,
  output logic [2:0]            o_Pattern
);

  localparam int                   RAMP_W   = COL_W + COLOR_BITS;
  localparam logic [COL_W-1:0]     C_LAST_COL = COL_W'(ACTIVE_COLS - 1);
  localparam logic [ROW_W-1:0]     C_LAST_ROW = ROW_W'(ACTIVE_ROWS - 1);
  localparam logic [COL_W-1:0]     C_BAR_W    = COL_W'(ACTIVE_COLS / 8);
  localparam logic [RAMP_W-1:0]    C_RAMP_DIV = RAMP_W'(ACTIVE_COLS);
  localparam logic [COLOR_BITS-1:0] C_MAX     = '1;

  logic             r_HSync_1;
  logic             r_VSync_1;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [2:0]       r_Pattern;

  logic w_h_rise;
  logic w_h_fall;
  logic w_v_rise;
  logic w_active;

  assign w_h_rise = i_HSync & ~r_HSync_1;
  assign w_h_fall = ~i_HSync & r_HSync_1;
  assign w_v_rise = i_VSync & ~r_VSync_1;
  assign w_active = r_HSync_1 & r_VSync_1 & (r_col <= C_LAST_COL) & (r_row <= C_LAST_ROW);

  // Stage 1: edge detection, position counters and frame-start pattern latch
  always_ff @(posedge CLK) begin
    if (!i_Rst_n) begin
      r_HSync_1 <= 1'b0;
      r_VSync_1 <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
      r_Pattern <= 3'd0;
    end else begin
      r_HSync_1 <= i_HSync;
      r_VSync_1 <= i_VSync;

      if (w_h_rise) begin
        r_col <= '0;
      end else if (i_HSync && (r_col != '1)) begin
        r_col <= r_col + 1'b1;
      end

      if (w_v_rise) begin
        r_row <= '0;
      end else if (w_h_fall && i_VSync && (r_row != '1)) begin
        r_row <= r_row + 1'b1;
      end

      if (w_v_rise) begin
        r_Pattern <= i_Pattern;
      end
    end
  end

  logic [2:0]            w_bar_c;
  logic [COLOR_BITS-1:0] w_grey;
  logic [COLOR_BITS-1:0] w_red;
  logic [COLOR_BITS-1:0] w_green;
  logic [COLOR_BITS-1:0] w_blue;
  logic                  w_white;

  // Bar 0 is white, so the bar index is inverted to form the RGB bit triple.
  assign w_bar_c = 3'd7 - 3'(r_col / C_BAR_W);
  assign w_grey  = COLOR_BITS'({r_col, {COLOR_BITS{1'b0}}} / C_RAMP_DIV);

  always_comb begin
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    w_white = 1'b0;
    if (w_active) begin
      case (r_Pattern)
        3'd1: w_red   = C_MAX;
        3'd2: w_green = C_MAX;
        3'd3: w_blue  = C_MAX;
        3'd4: begin
          w_red   = w_bar_c[2] ? C_MAX : '0;
          w_green = w_bar_c[1] ? C_MAX : '0;
          w_blue  = w_bar_c[0] ? C_MAX : '0;
        end
        3'd5: w_white = (r_col[CHECK_LOG2] == r_row[CHECK_LOG2]);
        3'd6: w_white = (r_col == '0) || (r_col == C_LAST_COL) ||
                        (r_row == '0) || (r_row == C_LAST_ROW);
        3'd7: begin
          w_red   = w_grey;
          w_green = w_grey;
          w_blue  = w_grey;
        end
        default: ;
      endcase
      if (w_white) begin
        w_red   = C_MAX;
        w_green = C_MAX;
        w_blue  = C_MAX;
      end
    end
  end

  // Stage 2: output registers keep sync and colour on the same cycle
  always_ff @(posedge CLK) begin
    if (!i_Rst_n) begin
      o_HSync <= 1'b0;
      o_VSync <= 1'b0;
      o_Red   <= '0;
      o_Green <= '0;
      o_Blue  <= '0;
    end else begin
      o_HSync <= r_HSync_1;
      o_VSync <= r_VSync_1;
      o_Red   <= w_red;
      o_Green <= w_green;
      o_Blue  <= w_blue;
    end
  end

  assign o_Pattern = r_Pattern;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pattern_gen
// Purpose  : Directed self-checking bench for vga_pattern_gen (default params).
// Revision : 1.0
// ============================================================================
module tb_vga_pattern_gen;

  localparam logic [8:0] C_BLACK  = 9'h000;
  localparam logic [8:0] C_WHITE  = 9'h1FF;
  localparam logic [8:0] C_RED    = 9'h1C0;
  localparam logic [8:0] C_GREEN  = 9'h038;
  localparam logic [8:0] C_BLUE   = 9'h007;
  localparam logic [8:0] C_YELLOW = 9'h1F8;
  localparam logic [8:0] C_CYAN   = 9'h03F;
  localparam logic [8:0] C_GREY1  = 9'h049;

  logic       CLK;
  logic       i_Rst_n;
  logic       i_HSync;
  logic       i_VSync;
  logic [2:0] i_Pattern;
  logic       o_HSync;
  logic       o_VSync;
  logic [2:0] o_Red;
  logic [2:0] o_Green;
  logic [2:0] o_Blue;
  logic [2:0] o_Pattern;

  int errors;
  int checks;

  logic [8:0] pix      [0:1023];
  logic       hs_trace [0:1023];

  vga_pattern_gen dut (
    .CLK       (CLK),
    .i_Rst_n   (i_Rst_n),
    .i_HSync   (i_HSync),
    .i_VSync   (i_VSync),
    .i_Pattern (i_Pattern),
    .o_HSync   (o_HSync),
    .o_VSync   (o_VSync),
    .o_Red     (o_Red),
    .o_Green   (o_Green),
    .o_Blue    (o_Blue),
    .o_Pattern (o_Pattern)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [8:0] rgb();
    return {o_Red, o_Green, o_Blue};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Holds i_HSync high for len cycles; pix[k] captures the output for column k.
  task automatic run_line(input int len);
    i_HSync = 1'b1;
    for (int j = 1; j <= len + 1; j++) begin
      tick();
      if (j == len) i_HSync = 1'b0;
      hs_trace[j] = o_HSync;
      if (j >= 2) pix[j-2] = rgb();
    end
    tick();
    tick();
  endtask

  task automatic short_line();
    i_HSync = 1'b1;
    tick();
    i_HSync = 1'b0;
    tick();
  endtask

  task automatic frame_start(input logic [2:0] pat);
    i_HSync = 1'b0;
    i_VSync = 1'b0;
    tick();
    tick();
    tick();
    i_Pattern = pat;
    i_VSync   = 1'b1;
    tick();
    check("vsync_lat1", 32'(o_VSync), 32'd0);
    check("pattern_latched", 32'(o_Pattern), 32'(pat));
    tick();
    check("vsync_lat2", 32'(o_VSync), 32'd1);
  endtask

  initial begin
    int bad;
    errors    = 0;
    checks    = 0;
    i_Rst_n   = 1'b0;
    i_HSync   = 1'b0;
    i_VSync   = 1'b0;
    i_Pattern = 3'd0;
    tick();
    tick();
    tick();
    check("reset_rgb", 32'(rgb()), 32'(C_BLACK));
    check("reset_hs", 32'(o_HSync), 32'd0);
    check("reset_vs", 32'(o_VSync), 32'd0);
    check("reset_pat", 32'(o_Pattern), 32'd0);
    i_Rst_n = 1'b1;
    tick();
    tick();
    check("post_reset_pat", 32'(o_Pattern), 32'd0);
    check("post_reset_rgb", 32'(rgb()), 32'(C_BLACK));

    // Solid red, then a mid-frame request for green that must wait
    frame_start(3'd1);
    run_line(640);
    check("red_col0", 32'(pix[0]), 32'(C_RED));
    check("red_col639", 32'(pix[639]), 32'(C_RED));
    i_Pattern = 3'd2;
    run_line(640);
    check("red_deferred", 32'(pix[100]), 32'(C_RED));
    check("pat_still1", 32'(o_Pattern), 32'd1);
    frame_start(3'd2);
    run_line(640);
    check("green_col0", 32'(pix[0]), 32'(C_GREEN));
    check("pat_now2", 32'(o_Pattern), 32'd2);
    i_Pattern = 3'd5;
    short_line();
    check("pat_ignored", 32'(o_Pattern), 32'd2);

    // Reset mid-line with syncs high, released with syncs still high
    i_Pattern = 3'd1;
    i_HSync   = 1'b1;
    tick();
    tick();
    tick();
    i_Rst_n = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("midreset_rgb", 32'(rgb()), 32'(C_BLACK));
    check("midreset_hs", 32'(o_HSync), 32'd0);
    check("midreset_vs", 32'(o_VSync), 32'd0);
    check("midreset_pat", 32'(o_Pattern), 32'd0);
    i_Rst_n = 1'b1;
    tick();
    check("release_pat", 32'(o_Pattern), 32'd1);
    tick();
    check("release_rgb", 32'(rgb()), 32'(C_RED));
    check("release_hs", 32'(o_HSync), 32'd1);
    i_HSync = 1'b0;
    tick();

    // Colour bars over an overlong line
    frame_start(3'd4);
    run_line(700);
    check("bars_col0", 32'(pix[0]), 32'(C_WHITE));
    check("bars_col79", 32'(pix[79]), 32'(C_WHITE));
    check("bars_col80", 32'(pix[80]), 32'(C_YELLOW));
    check("bars_col320", 32'(pix[320]), 32'(C_CYAN));
    check("bars_col559", 32'(pix[559]), 32'(C_BLUE));
    check("bars_col639", 32'(pix[639]), 32'(C_BLACK));
    check("bars_col640", 32'(pix[640]), 32'(C_BLACK));
    check("bars_col699", 32'(pix[699]), 32'(C_BLACK));

    // Checkerboard
    frame_start(3'd5);
    run_line(640);
    check("chk_31_0", 32'(pix[31]), 32'(C_WHITE));
    check("chk_32_0", 32'(pix[32]), 32'(C_BLACK));
    for (int i = 0; i < 31; i++) short_line();
    run_line(640);
    check("chk_32_32", 32'(pix[32]), 32'(C_WHITE));
    check("chk_0_32", 32'(pix[0]), 32'(C_BLACK));

    // Grey ramp
    frame_start(3'd7);
    run_line(640);
    check("grey_col0", 32'(pix[0]), 32'(C_BLACK));
    check("grey_col79", 32'(pix[79]), 32'(C_BLACK));
    check("grey_col80", 32'(pix[80]), 32'(C_GREY1));
    check("grey_col639", 32'(pix[639]), 32'(C_WHITE));

    // Border, including latency of the first pixel after i_HSync rises
    frame_start(3'd6);
    run_line(640);
    check("lat_hs_n1", 32'(hs_trace[1]), 32'd0);
    check("lat_hs_n2", 32'(hs_trace[2]), 32'd1);
    check("lat_col0_white", 32'(pix[0]), 32'(C_WHITE));
    run_line(640);
    check("border_r1_c0", 32'(pix[0]), 32'(C_WHITE));
    check("border_r1_c1", 32'(pix[1]), 32'(C_BLACK));
    check("border_r1_c638", 32'(pix[638]), 32'(C_BLACK));
    check("border_r1_c639", 32'(pix[639]), 32'(C_WHITE));
    for (int i = 0; i < 477; i++) short_line();
    run_line(640);
    bad = 0;
    for (int k = 0; k < 640; k++) if (pix[k] !== C_WHITE) bad++;
    check("border_r479_nonwhite", 32'(bad), 32'd0);
    run_line(640);
    bad = 0;
    for (int k = 0; k < 640; k++) if (pix[k] !== C_BLACK) bad++;
    check("border_r480_nonblack", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
